// File: rtl/spi_burst_ram_pkg.sv
// Shared command encodings and read-tracking state for the SPI burst RAM.
package spi_ram_pkg;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_WR_ADDR = 2'b00;
    localparam cmd_t CMD_WR_DATA = 2'b01;
    localparam cmd_t CMD_RD_ADDR = 2'b10;
    localparam cmd_t CMD_RD_DATA = 2'b11;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_PEND = 1'b1
    } rd_state_t;

endpackage

// File: rtl/spi_burst_ram_if.sv
// Command/response bundle between the SPI slave (master side) and the burst RAM.
interface spi_burst_ram_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W+1:0] din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              addr_err;

    modport master (output din, rx_valid, input dout, tx_valid, addr_err);
    modport slave  (input din, rx_valid, output dout, tx_valid, addr_err);
endinterface

// File: rtl/spi_burst_ram_mem.sv
// Single-port-write / registered-read word array used by spi_burst_ram.
module spi_ram_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rd_ok,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto RAM macros; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= rd_ok ? mem_q[raddr] : '0;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/spi_burst_ram.sv
// Command-driven RAM behind an SPI slave: pointer registers, decode, range check, read pipeline.
// Optional burst auto-increment of both pointers when SPI_RAM_AUTOINC_EN is defined.
module spi_burst_ram
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_burst_ram_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

    cmd_t              cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] addr_in;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    rd_state_t         state_q, state_d;
    logic              err_q, err_d;
    logic              wr_ok, rd_ok;
    logic              accept_wr, accept_rd;

    assign cmd       = bus.din[DATA_W+1:DATA_W];
    assign payload   = bus.din[DATA_W-1:0];
    assign addr_in   = payload[ADDR_W-1:0];
    assign wr_ok     = {1'b0, wr_addr_q} < DEPTH_L;
    assign rd_ok     = {1'b0, rd_addr_q} < DEPTH_L;
    assign accept_wr = bus.rx_valid && (cmd == CMD_WR_DATA);
    assign accept_rd = bus.rx_valid && (cmd == CMD_RD_DATA);

`ifdef SPI_RAM_AUTOINC_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    // Wraps at the last real word; out-of-range pointers roll over the full pointer width.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ADDR_W'(1);
    endfunction
`endif

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        state_d   = RD_IDLE;
        err_d     = 1'b0;
        if (bus.rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: wr_addr_d = addr_in;
                CMD_WR_DATA: begin
                    err_d = !wr_ok;
`ifdef SPI_RAM_AUTOINC_EN
                    wr_addr_d = ptr_inc(wr_addr_q);
`endif
                end
                CMD_RD_ADDR: rd_addr_d = addr_in;
                CMD_RD_DATA: begin
                    state_d = RD_PEND;
                    err_d   = !rd_ok;
`ifdef SPI_RAM_AUTOINC_EN
                    rd_addr_d = ptr_inc(rd_addr_q);
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            state_q   <= RD_IDLE;
            err_q     <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            state_q   <= state_d;
            err_q     <= err_d;
        end
    end

    spi_ram_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept_wr && wr_ok),
        .waddr (wr_addr_q),
        .wdata (payload),
        .re    (accept_rd),
        .rd_ok (rd_ok),
        .raddr (rd_addr_q),
        .rdata (bus.dout)
    );

    assign bus.tx_valid = (state_q == RD_PEND);
    assign bus.addr_err = err_q;
endmodule

// File: doc/spi_burst_ram.md
Name: spi_burst_ram

Overview:
- Parametrised command-driven RAM that sits behind the SPI slave.
- Consumes {cmd[1:0], payload} words on rx_valid; returns read data with a one-cycle tx_valid pulse for the SPI slave to shift out.
- Next generation of the single-address SPI RAM: configurable data/address width and depth, independent write and read address pointers, pipelined back-to-back reads, out-of-range error reporting, optional burst auto-increment.

Parameters:
- DATA_W, 8, memory word width; also the payload width of din.
- ADDR_W, 8, address pointer width (must be ≤ DATA_W; address taken from din[ADDR_W-1:0]).
- MEM_DEPTH, 256, number of words; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DATA_W+2  din[DATA_W+1:DATA_W] = command, din[DATA_W-1:0] = payload.
- rx_valid  input  1  din valid this cycle; one command per asserted cycle.
- dout  output  DATA_W  read data, held until next read completes.
- tx_valid  output  1  one-cycle pulse: dout updated this cycle.
- addr_err  output  1  one-cycle pulse: command hit an address ≥ MEM_DEPTH.

Behaviour:
- Reset (async, rst_n=0):
  - dout=0, tx_valid=0, addr_err=0.
  - wr_addr=0, rd_addr=0, rd_pend=0.
  - Memory contents are not cleared.
- Commands are acted on only when rx_valid=1. With rx_valid=0, registers hold, and tx_valid/addr_err are 0 except for completion of an already-pending read.
- Command 00 (WR_ADDR): wr_addr <= din[ADDR_W-1:0].
- Command 01 (WR_DATA): mem[wr_addr] <= din[DATA_W-1:0].
  - If wr_addr ≥ MEM_DEPTH: write suppressed, addr_err pulses next cycle.
- Command 10 (RD_ADDR): rd_addr <= din[ADDR_W-1:0]. Payload bits above ADDR_W are ignored.
- Command 11 (RD_DATA): payload ignored. Launches read of mem[rd_addr] and sets rd_pend for one cycle.
  - Next cycle: dout <= read word, tx_valid=1.
  - Fixed latency of exactly 1 cycle from the accepting edge to tx_valid high.
  - If rd_addr ≥ MEM_DEPTH: dout <= 0, tx_valid=1, addr_err=1 in the same cycle.
- Pipelining: RD_DATA on consecutive cycles gives tx_valid on consecutive cycles, in order. No stall input; the downstream SPI slave must accept every pulse.
- Read/write hazard: WR_DATA and RD_DATA target the same address only in different cycles. A RD_DATA accepted the cycle after WR_DATA returns the newly written value (write lands at the WR_DATA edge).
- Read state tracking (rd_pend): IDLE -> PEND on accepted RD_DATA. PEND -> IDLE, or PEND -> PEND if another RD_DATA is accepted.
- Reset mid-operation: a pending read is discarded. No tx_valid is issued after reset deasserts.
- Address pointers never exceed ADDR_W bits. Arithmetic is unsigned.

Optional Feature:
- Macro: SPI_RAM_AUTOINC_EN.
- Defined:
  - After each accepted WR_DATA, wr_addr <= wr_addr+1.
  - After each accepted RD_DATA, rd_addr <= rd_addr+1.
  - Both wrap MEM_DEPTH-1 -> 0, so auto-increment never produces an out-of-range address.
  - Increment also occurs on an errored access (pointer ≥ MEM_DEPTH): the pointer increments modulo 2**ADDR_W.
- Undefined: pointers change only via WR_ADDR/RD_ADDR; repeated data commands hit the same address.

Decomposition:
- Package spi_ram_pkg holds:
  - command encodings CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - a cmd_t 2-bit typedef.
- Sub-module spi_ram_mem:
  - MEM_DEPTH×DATA_W array;
  - synchronous write enable;
  - registered synchronous read;
  - no reset on the array.
- Top level holds pointer registers, decode, range check, rd_pend and output registers.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle -> dout=0, tx_valid=0, addr_err=0 immediately. Issue RD_DATA the cycle before reset -> no tx_valid after release.
- Basic write/read: WR_ADDR 0x12, WR_DATA 0xA5, RD_ADDR 0x12, RD_DATA -> tx_valid high exactly 1 cycle after RD_DATA, dout=0xA5.
- Back-to-back reads: preload 0x00=0x11, 0x01=0x22, 0x02=0x33. With macro, RD_ADDR 0x00 then RD_DATA×3 on consecutive cycles -> tx_valid high 3 consecutive cycles, dout 0x11, 0x22, 0x33.
- Wrap (macro on, MEM_DEPTH=256): WR_ADDR 0xFF, WR_DATA 0x5A, WR_DATA 0xC3 -> mem[0xFF]=0x5A, mem[0x00]=0xC3.
- Out of range (MEM_DEPTH=200): WR_ADDR 0xD0, WR_DATA 0x77 -> addr_err pulse, no memory change. RD_ADDR 0xD0, RD_DATA -> tx_valid=1, dout=0x00, addr_err=1.
- Macro off: WR_ADDR 0x05, WR_DATA 0x01, WR_DATA 0x02, RD_ADDR 0x05, RD_DATA×2 -> both reads return 0x02; mem[0x06] unchanged.
